card_dealer: RTL and testbench

Sequential source of 4-bit card codes (0 = no card, 1 = Ace … 13 = King) for the seven-segment card displays and the hand-scoring logic. On each deal request it picks a rank from a free-running 1..13 counter, so the value depends on the player's timing. It tracks how many copies of each rank remain in a shoe of NUM_DECKS decks, skips exhausted ranks, and reports an empty shoe. It sits between the player/controller FSM and the per-card display registers.

---
 rtl/card_pkg.sv | 29 ++
 rtl/rank_counter.sv | 26 ++
 rtl/card_dealer.sv | 125 ++++++++++++
 tb/tb_card_dealer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Card codes and shoe constants shared by the dealer and the display decoders.
package card_pkg;

  typedef enum logic [3:0] {
    CARD_NONE  = 4'd0,
    CARD_ACE   = 4'd1,
    CARD_TWO   = 4'd2,
    CARD_THREE = 4'd3,
    CARD_FOUR  = 4'd4,
    CARD_FIVE  = 4'd5,
    CARD_SIX   = 4'd6,
    CARD_SEVEN = 4'd7,
    CARD_EIGHT = 4'd8,
    CARD_NINE  = 4'd9,
    CARD_TEN   = 4'd10,
    CARD_JACK  = 4'd11,
    CARD_QUEEN = 4'd12,
    CARD_KING  = 4'd13
  } card_t;

  localparam int NUM_RANKS      = 13;
  localparam int CARDS_PER_DECK = 52;

  // Ace follows King; any out-of-range code also recovers to Ace.
  function automatic logic [3:0] next_rank(input logic [3:0] r);
    return (r >= 4'(CARD_KING)) ? 4'(CARD_ACE) : r + 4'd1;
  endfunction

endpackage

// File: rtl/rank_counter.sv
// Free-running Ace..King counter; its phase at request time picks the dealt rank.
module rank_counter
  import card_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rank_o
);

  logic [3:0] rank_q, rank_d;

  always_comb begin
    rank_d = next_rank(rank_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rank_q <= 4'(CARD_ACE);
    end else begin
      rank_q <= rank_d;
    end
  end

  assign rank_o = rank_q;

endmodule

// File: rtl/card_dealer.sv
// Deals ranks from a shoe of NUM_DECKS decks, starting at the free-running rank
// and walking forward past exhausted ranks.
module card_dealer
  import card_pkg::*;
#(
  parameter int unsigned NUM_DECKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_req,
  input  logic       reshuffle,
  output logic [3:0] new_card,
  output logic       card_valid,
  output logic       deck_empty,
  output logic [8:0] cards_left
);

  localparam int unsigned PerRank = 4 * NUM_DECKS;
  localparam int unsigned CntW    = $clog2(PerRank + 1);
  localparam logic [CntW-1:0] FullRank = CntW'(PerRank);
  localparam logic [8:0]      FullShoe = 9'(CARDS_PER_DECK * NUM_DECKS);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSearch  = 2'd1;
  localparam logic [1:0] StPresent = 2'd2;

  logic [3:0]      rank_ctr;
  logic [1:0]      state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      new_card_q, new_card_d;
  logic            card_valid_q, card_valid_d;
  logic            deck_empty_q, deck_empty_d;
  logic [8:0]      cards_left_q, cards_left_d;
  logic [CntW-1:0] remaining_q [1:NUM_RANKS];
  logic            refill, take;

  rank_counter u_rank_counter (
    .clk    (clk),
    .rst    (rst),
    .rank_o (rank_ctr)
  );

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    new_card_d   = new_card_q;
    card_valid_d = 1'b0;
    deck_empty_d = deck_empty_q;
    cards_left_d = cards_left_q;
    refill       = 1'b0;
    take         = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A reshuffle swallows any request arriving in the same cycle.
        if (reshuffle) begin
          refill       = 1'b1;
          cards_left_d = FullShoe;
          new_card_d   = 4'(CARD_NONE);
          deck_empty_d = 1'b0;
        end else if (deal_req) begin
          if (deck_empty_q) begin
            new_card_d   = 4'(CARD_NONE);
            card_valid_d = 1'b1;
            state_d      = StPresent;
          end else begin
            cand_d  = rank_ctr;
            state_d = StSearch;
          end
        end
      end
      StSearch: begin
        if (remaining_q[cand_q] != '0) begin
          take         = 1'b1;
          cards_left_d = cards_left_q - 9'd1;
          deck_empty_d = (cards_left_q == 9'd1);
          new_card_d   = cand_q;
          card_valid_d = 1'b1;
          state_d      = StPresent;
        end else begin
          cand_d = next_rank(cand_q);
        end
      end
      StPresent: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cand_q       <= 4'(CARD_ACE);
      new_card_q   <= 4'(CARD_NONE);
      card_valid_q <= 1'b0;
      deck_empty_q <= 1'b0;
      cards_left_q <= FullShoe;
      for (int r = 1; r <= NUM_RANKS; r++) begin
        remaining_q[r] <= FullRank;
      end
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      new_card_q   <= new_card_d;
      card_valid_q <= card_valid_d;
      deck_empty_q <= deck_empty_d;
      cards_left_q <= cards_left_d;
      if (refill) begin
        for (int r = 1; r <= NUM_RANKS; r++) begin
          remaining_q[r] <= FullRank;
        end
      end else if (take) begin
        remaining_q[cand_q] <= remaining_q[cand_q] - CntW'(1);
      end
    end
  end

  assign new_card   = new_card_q;
  assign card_valid = card_valid_q;
  assign deck_empty = deck_empty_q;
  assign cards_left = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed and random deals checked against a shoe model driven by cycle count.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst, deal_req, reshuffle;
  logic [3:0] new_card;
  logic       card_valid, deck_empty;
  logic [8:0] cards_left;
  logic       deal_req2, reshuffle2;
  logic [3:0] new_card2;
  logic       card_valid2, deck_empty2;
  logic [8:0] cards_left2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rem [1:13];
  int cards;

  always #5 clk = ~clk;

  // Cycles since reset; the rank on offer is a pure function of it.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  card_dealer #(.NUM_DECKS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .deal_req   (deal_req),
    .reshuffle  (reshuffle),
    .new_card   (new_card),
    .card_valid (card_valid),
    .deck_empty (deck_empty),
    .cards_left (cards_left)
  );

  card_dealer #(.NUM_DECKS(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .deal_req   (deal_req2),
    .reshuffle  (reshuffle2),
    .new_card   (new_card2),
    .card_valid (card_valid2),
    .deck_empty (deck_empty2),
    .cards_left (cards_left2)
  );

  function automatic int rank_now();
    return cyc % 13 + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_refill();
    for (int r = 1; r <= 13; r++) rem[r] = 4;
    cards = 52;
  endtask

  task automatic do_reshuffle();
    reshuffle = 1'b1;
    step();
    reshuffle = 1'b0;
    model_refill();
    check("reshuffle cards_left", cards_left, 52);
  endtask

  // target 0 requests immediately; poke strobes deal_req+reshuffle during SEARCH.
  task automatic deal(input int target, input bit poke, input string tag);
    int c, exp_card, exp_lat, lat;
    for (int i = 0; i < 13 && target != 0 && rank_now() != target; i++) step();
    c = rank_now();
    if (cards == 0) begin
      exp_card = 0;
      exp_lat  = 1;
    end else begin
      exp_lat = 2;
      while (rem[c] == 0) begin
        c = (c == 13) ? 1 : c + 1;
        exp_lat++;
      end
      exp_card = c;
      rem[c]--;
      cards--;
    end
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    lat = 1;
    while (!card_valid && lat < 20) begin
      if (poke && lat == 1) begin
        deal_req  = 1'b1;
        reshuffle = 1'b1;
      end
      step();
      deal_req  = 1'b0;
      reshuffle = 1'b0;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " new_card"}, new_card, exp_card);
    check({tag, " cards_left"}, cards_left, cards);
    check({tag, " deck_empty"}, deck_empty, (cards == 0));
    step();
    check({tag, " pulse width"}, card_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1; deal_req = 1'b0; reshuffle = 1'b0; deal_req2 = 1'b0; reshuffle2 = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_refill();

    check("reset new_card", new_card, 0);
    check("reset card_valid", card_valid, 0);
    check("reset deck_empty", deck_empty, 0);
    check("reset cards_left", cards_left, 52);
    check("reset2 cards_left", cards_left2, 104);
    check("reset2 deck_empty", deck_empty2, 0);
    repeat (10) step();
    check("rank_ctr after 10", dut.rank_ctr, 11);

    // Simple deal, with a request and reshuffle arriving mid-search.
    deal(5, 1'b1, "simple");
    check("simple cards_left", cards_left, 51);
    pulses = 0;
    repeat (16) begin
      step();
      if (card_valid) pulses++;
    end
    check("ignored requests pulses", pulses, 0);
    check("ignored reshuffle cards_left", cards_left, 51);

    repeat (4) deal(7, 1'b0, "exhaust7");
    deal(7, 1'b0, "skip7");
    check("skip7 card", new_card, 8);

    // Reshuffle beats a same-cycle deal request.
    reshuffle = 1'b1;
    deal_req  = 1'b1;
    step();
    reshuffle = 1'b0;
    deal_req  = 1'b0;
    model_refill();
    pulses = 0;
    repeat (4) begin
      if (card_valid) pulses++;
      step();
    end
    check("reshuffle+deal pulses", pulses, 0);
    check("reshuffle+deal cards_left", cards_left, 52);
    check("reshuffle+deal new_card", new_card, 0);
    check("reshuffle+deal deck_empty", deck_empty, 0);

    repeat (40) begin
      if ($urandom_range(0, 7) == 0) do_reshuffle();
      else deal(int'($urandom_range(1, 13)), 1'b0, "random");
    end

    // Drain everything except rank 1, then wrap onto it from King.
    do_reshuffle();
    for (int r = 2; r <= 13; r++) begin
      repeat (4) deal(r, 1'b0, "drain");
    end
    repeat (3) deal(1, 1'b0, "drain ace");
    deal(13, 1'b0, "wrap");
    check("wrap card", new_card, 1);
    check("drained deck_empty", deck_empty, 1);
    check("drained cards_left", cards_left, 0);
    deal(0, 1'b0, "empty");
    deal(0, 1'b0, "empty again");

    // Reset while searching must suppress the pending card.
    do_reshuffle();
    for (int i = 0; i < 13 && rank_now() != 3; i++) step();
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_refill();
    pulses = 0;
    repeat (6) begin
      if (card_valid) pulses++;
      step();
    end
    check("midsearch reset pulses", pulses, 0);
    check("midsearch reset cards_left", cards_left, 52);
    check("midsearch reset new_card", new_card, 0);
    check("midsearch reset deck_empty", deck_empty, 0);

    // Two-deck shoe.
    check("two-deck cards_left", cards_left2, 104);
    for (int i = 0; i < 13 && rank_now() != 4; i++) step();
    deal_req2 = 1'b1;
    step();
    deal_req2 = 1'b0;
    check("two-deck early valid", card_valid2, 0);
    step();
    check("two-deck valid", card_valid2, 1);
    check("two-deck card", new_card2, 4);
    check("two-deck cards_left after", cards_left2, 103);
    step();
    check("two-deck pulse width", card_valid2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
